// File: rtl/cache_data_pkg.sv
// cache_data_pkg: shared state encoding, default geometry and byte-mask helper for the cache data array.
package cache_data_pkg;
    typedef enum logic {ST_IDLE, ST_FILL} state_t;
    localparam int DEF_LINES = 8;
    localparam int DEF_LINE_BYTES = 32;
    localparam int DEF_FILL_BYTES = 8;
    function automatic logic [7:0] byte_mask_expand(input logic en);
        return {8{en}};
    endfunction
endpackage

// File: rtl/cache_data_line.sv
// cache_data_line: one cache line of byte registers, each byte with its own write enable.
module cache_data_line
    import cache_data_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LINE_BYTES-1:0]   we,
    input  logic [LINE_BYTES*8-1:0] wdata,
    output logic [LINE_BYTES*8-1:0] rdata
);
    logic [LINE_BYTES*8-1:0] data_q, data_d;
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < LINE_BYTES; i++)
            data_d[8*i +: 8] = (data_q[8*i +: 8] & ~byte_mask_expand(we[i])) |
                               (wdata[8*i +: 8] & byte_mask_expand(we[i]));
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    assign rdata = data_q;
endmodule

// File: rtl/cache_data_array.sv
// cache_data_array: LINES x LINE_BYTES data store with masked stores, registered line
// reads and a multi-beat line-fill engine fed from a narrower refill bus.
module cache_data_array
    import cache_data_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int FILL_BYTES = DEF_FILL_BYTES,
    localparam int IW    = $clog2(LINES),
    localparam int BEATS = LINE_BYTES / FILL_BYTES,
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1,
    localparam int LW    = LINE_BYTES * 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic [IW-1:0]           rd_idx,
    output logic                    rd_valid,
    output logic [LW-1:0]           rd_data,
    input  logic                    wr_en,
    output logic                    wr_ready,
    input  logic [IW-1:0]           wr_idx,
    input  logic [LINE_BYTES-1:0]   wr_mask,
    input  logic [LW-1:0]           wr_data,
    input  logic                    fill_start,
    input  logic [IW-1:0]           fill_idx,
    input  logic                    fill_valid,
    input  logic [FILL_BYTES*8-1:0] fill_data,
    output logic                    fill_ready,
    output logic                    fill_done
);
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    rd_valid_q, rd_valid_d, fill_done_q, fill_done_d;
    logic [LW-1:0]           rd_data_q, rd_data_d, line_wdata;
    logic [LW-1:0]           line_q [LINES];
    logic [LINE_BYTES-1:0]   line_we [LINES];
    logic [LINE_BYTES-1:0]   beat_mask;
    logic                    store_go, beat_go, last_beat;

    assign store_go   = wr_en && state_q == ST_IDLE;
    assign beat_go    = fill_valid && state_q == ST_FILL;
    assign last_beat  = cnt_q == CW'(BEATS - 1);
    assign beat_mask  = LINE_BYTES'({FILL_BYTES{1'b1}}) << (cnt_q * FILL_BYTES);
    // Beat data is replicated across the line; the byte enables pick the slot.
    assign line_wdata = store_go ? wr_data : {BEATS{fill_data}};

    always_comb begin
        for (int l = 0; l < LINES; l++)
            line_we[l] = store_go && wr_idx == IW'(l) ? wr_mask :
                         beat_go && idx_q == IW'(l) ? beat_mask : '0;
    end

    for (genvar g = 0; g < LINES; g++) begin : g_line
        cache_data_line #(.LINE_BYTES(LINE_BYTES)) u_line (
            .clk  (clk),
            .reset(reset),
            .we   (line_we[g]),
            .wdata(line_wdata),
            .rdata(line_q[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        fill_done_d = beat_go && last_beat;
        rd_valid_d  = rd_en;
        rd_data_d   = rd_en ? line_q[rd_idx] : rd_data_q;
        if (state_q == ST_IDLE && fill_start) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            idx_d   = fill_idx;
        end else if (beat_go) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = last_beat ? ST_IDLE : ST_FILL;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            fill_done_q <= fill_done_d;
        end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign fill_done  = fill_done_q;
    assign wr_ready   = state_q == ST_IDLE;
    assign fill_ready = state_q == ST_FILL;
endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array: randomized and directed scoreboard bench against a byte-array model.
module tb_cache_data_array;
    logic         clk = 0, reset = 1;
    logic         rd_en = 0, wr_en = 0, fill_start = 0, fill_valid = 0;
    logic [2:0]   rd_idx = 0, wr_idx = 0, fill_idx = 0;
    logic [31:0]  wr_mask = 0;
    logic [255:0] wr_data = 0;
    logic [63:0]  fill_data = 0;
    logic         rd_valid, wr_ready, fill_ready, fill_done;
    logic [255:0] rd_data;

    cache_data_array dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_data(rd_data), .wr_en(wr_en), .wr_ready(wr_ready), .wr_idx(wr_idx),
        .wr_mask(wr_mask), .wr_data(wr_data), .fill_start(fill_start), .fill_idx(fill_idx),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    logic [7:0]   mem [8][32];
    logic [255:0] sb[$];
    logic [255:0] last_rd = 0;
    bit           busy = 0, done_exp = 0;
    int           fidx = 0, beat = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [255:0] pack(input int i);
        logic [255:0] v;
        for (int b = 0; b < 32; b++) v[8*b +: 8] = mem[i][b];
        return v;
    endfunction

    always @(negedge clk)
        if (!reset) begin
            if (rd_valid) begin
                if (sb.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    last_rd = sb.pop_front();
                    chk("rd_data", rd_data, last_rd);
                end
            end else chk("rd_hold", rd_data, last_rd);
        end

    task automatic tick();
        if (rd_en) sb.push_back(pack(int'(rd_idx)));
        done_exp = 0;
        if (!busy) begin
            if (wr_en)
                for (int b = 0; b < 32; b++) if (wr_mask[b]) mem[wr_idx][b] = wr_data[8*b +: 8];
            if (fill_start) begin busy = 1; fidx = int'(fill_idx); beat = 0; end
        end else if (fill_valid) begin
            for (int b = 0; b < 8; b++) mem[fidx][beat*8 + b] = fill_data[8*b +: 8];
            beat++;
            if (beat == 4) begin busy = 0; done_exp = 1; end
        end
        @(posedge clk); #1;
        chk("fill_done", fill_done, done_exp);
        chk("wr_ready", wr_ready, !busy);
        chk("fill_ready", fill_ready, busy);
        rd_en = 0; wr_en = 0; fill_start = 0; fill_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        rd_en = 0; wr_en = 0; fill_start = 0; fill_valid = 0;
        for (int i = 0; i < 8; i++) for (int b = 0; b < 32; b++) mem[i][b] = 0;
        sb.delete(); last_rd = 0; busy = 0; beat = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fill_ready", fill_ready, 0);
        chk("rst_fill_done", fill_done, 0);
        #1 reset = 0;
    endtask

    task automatic rd(input int i);
        rd_en = 1; rd_idx = 3'(i); tick();
    endtask

    task automatic st(input int i, input logic [31:0] m, input logic [255:0] d);
        wr_en = 1; wr_idx = 3'(i); wr_mask = m; wr_data = d;
    endtask

    task automatic beat_in(input logic [63:0] d);
        fill_valid = 1; fill_data = d; tick();
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 8; i++) rd(i);
        tick();
        st(3, 32'h0000_000F, 256'hFFFF_A3A2_A1A0); tick();
        rd(3);
        fill_start = 1; fill_idx = 5; tick();
        beat_in({8{8'h11}});
        tick();
        st(5, 32'hFFFF_FFFF, {8{32'hDEAD_BEEF}}); beat_in({8{8'h22}});
        beat_in({8{8'h33}});
        fill_start = 1; fill_idx = 1; beat_in({8{8'h44}});
        rd(5);
        st(5, 32'h0000_0F00, {8{32'hDEAD_BEEF}}); tick();
        rd(5);
        st(2, 32'h1, 256'hFF); rd(2);
        rd(2);
        fill_start = 1; fill_idx = 6; tick();
        beat_in({8{8'h55}});
        beat_in({8{8'h66}});
        do_reset();
        for (int i = 0; i < 8; i++) rd(i);
        fill_start = 1; fill_idx = 6; rd(6);
        for (int k = 0; k < 4; k++) begin rd_en = 1; rd_idx = 6; beat_in({8{8'(8'h70 + k)}}); end
        rd(6);
        for (int n = 0; n < 3000; n++) begin
            rd_en = 1'($urandom_range(0, 1)); rd_idx = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wr_en = 1; wr_idx = 3'($urandom); wr_mask = $urandom;
                for (int w = 0; w < 8; w++) wr_data[32*w +: 32] = $urandom;
            end
            fill_start = $urandom_range(0, 9) == 0; fill_idx = 3'($urandom);
            fill_valid = $urandom_range(0, 9) < 7; fill_data = {$urandom, $urandom};
            tick();
            if (n == 1500) do_reset();
        end
        repeat (3) tick();
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        chk("sb_drain", 256'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
